// File: rtl/fft_pkg.sv
// Shared constants for the SDF FFT datapath.
// Frame defaults and constant-multiplier address encodings.
package fft_pkg;

  localparam int FFT_NFFT   = 64;
  localparam int FFT_DELAY  = 4;
  localparam int DATA_WIDTH = 16;
  localparam int TW_AW      = 6;

  localparam logic [TW_AW-1:0] TW_W0   = 6'd0;
  localparam logic [TW_AW-1:0] TW_W8_1 = 6'd1;
  localparam logic [TW_AW-1:0] TW_W8_2 = 6'd2;
  localparam logic [TW_AW-1:0] TW_W8_3 = 6'd3;

endpackage

// File: rtl/fft_twiddle_sequencer.sv
// Control sequencer for one SDF radix-2 stage.
// Drives butterfly enable, twiddle address and output framing.
module fft_twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int NFFT  = FFT_NFFT,
  parameter int DELAY = FFT_DELAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sop,
  output logic       bf_en,
  output logic [5:0] tw_addr,
  output logic       out_valid,
  output logic       out_sop,
  output logic       sop_err
);

  localparam int LD = $clog2(DELAY);
  localparam int SH = 2 - LD;

  localparam logic [5:0] CNT_LAST = 6'(NFFT - 1);
  localparam logic [5:0] CNT_FILL = 6'(DELAY - 1);
  localparam logic [5:0] CNT_SOP  = 6'(DELAY);
  localparam logic [LD:0] JOFF    = (LD+1)'(DELAY);

  logic [5:0]  cnt;
  logic [5:0]  cnt_acc;
  logic [5:0]  cnt_nxt;
  logic        primed;
  logic        primed_now;
  logic        sop_acc;
  logic        realign;
  logic [LD:0] j_lo;
  logic [5:0]  tw_nxt;

  // Accepted-sample index, realignment and next twiddle address.
  always_comb begin
    sop_acc    = in_valid & in_sop;
    realign    = sop_acc & (cnt != '0);
    cnt_acc    = sop_acc ? '0 : cnt;
    cnt_nxt    = (cnt_acc == CNT_LAST) ? '0
                                       : cnt_acc + 6'd1;
    primed_now = primed & ~realign;
    j_lo       = cnt_acc[LD:0] - JOFF;
    tw_nxt     = TW_W0;
    if (j_lo[LD])
      tw_nxt = 6'(j_lo[LD-1:0]) << SH;
  end

  // Input counter and priming state advance per accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      cnt    <= cnt_nxt;
      primed <= primed_now | (cnt_acc == CNT_FILL);
    end
  end

  // Butterfly phase and twiddle address hold across input gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bf_en   <= 1'b0;
      tw_addr <= TW_W0;
    end else if (in_valid) begin
      bf_en   <= cnt_acc[LD];
      tw_addr <= tw_nxt;
    end
  end

  // Output framing aligned with the multiplier product register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
    end else begin
      out_valid <= in_valid & primed_now;
      out_sop   <= in_valid & primed_now &
                   (cnt_acc == CNT_SOP);
    end
  end

  // Sticky misaligned-sop flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sop_err <= 1'b0;
    else if (realign)
      sop_err <= 1'b1;
  end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Bench for fft_twiddle_sequencer, DELAY=4 and DELAY=2.
// Directed vector table plus hand sequences.
module tb_fft_twiddle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sop;
  logic       bf4, ov4, os4, er4;
  logic       bf2, ov2, os2, er2;
  logic [5:0] tw4, tw2;

  always #5 clk = ~clk;

  fft_twiddle_sequencer #(.NFFT(64), .DELAY(4)) u_d4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop),
    .bf_en(bf4), .tw_addr(tw4),
    .out_valid(ov4), .out_sop(os4), .sop_err(er4)
  );

  fft_twiddle_sequencer #(.NFFT(64), .DELAY(2)) u_d2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop),
    .bf_en(bf2), .tw_addr(tw2),
    .out_valid(ov2), .out_sop(os2), .sop_err(er2)
  );

  typedef struct {
    int v, s;
    int bf4, tw4, ov4, os4;
    int bf2, tw2, ov2, os2;
  } vec_t;

  vec_t vt[14];

  int n_chk = 0;
  int n_pass = 0;

  int tab4[8] = '{0, 0, 0, 0, 0, 1, 2, 3};
  int tab2[4] = '{0, 0, 0, 2};

  int mk, acc, merr;
  int e_bf4, e_tw4, e_ov4, e_os4;
  int e_bf2, e_tw2, e_ov2, e_os2;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0d want %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    mk = 0; acc = 0; merr = 0;
    e_bf4 = 0; e_tw4 = 0; e_ov4 = 0; e_os4 = 0;
    e_bf2 = 0; e_tw2 = 0; e_ov2 = 0; e_os2 = 0;
  endtask

  task automatic model_step(input int v, input int s);
    int k;
    if (v != 0) begin
      k = (s != 0) ? 0 : mk;
      if (s != 0 && mk != 0) begin
        merr = 1;
        acc = 0;
      end
      e_bf4 = ((k % 8) >= 4) ? 1 : 0;
      e_tw4 = tab4[(k + 60) % 8];
      e_ov4 = (acc >= 4) ? 1 : 0;
      e_os4 = (e_ov4 == 1 && k == 4) ? 1 : 0;
      e_bf2 = ((k % 4) >= 2) ? 1 : 0;
      e_tw2 = tab2[(k + 62) % 4];
      e_ov2 = (acc >= 2) ? 1 : 0;
      e_os2 = (e_ov2 == 1 && k == 2) ? 1 : 0;
      if (acc < 1000) acc++;
      mk = (k + 1) % 64;
    end else begin
      e_ov4 = 0; e_os4 = 0;
      e_ov2 = 0; e_os2 = 0;
    end
  endtask

  task automatic tick(input int v, input int s);
    @(negedge clk);
    in_valid = (v != 0);
    in_sop   = (s != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string t);
    chk({t, ".bf4"}, int'(bf4), e_bf4);
    chk({t, ".tw4"}, int'(tw4), e_tw4);
    chk({t, ".ov4"}, int'(ov4), e_ov4);
    chk({t, ".os4"}, int'(os4), e_os4);
    chk({t, ".er4"}, int'(er4), merr);
    chk({t, ".bf2"}, int'(bf2), e_bf2);
    chk({t, ".tw2"}, int'(tw2), e_tw2);
    chk({t, ".ov2"}, int'(ov2), e_ov2);
    chk({t, ".os2"}, int'(os2), e_os2);
    chk({t, ".er2"}, int'(er2), merr);
  endtask

  task automatic step(input int v, input int s,
                      input string t);
    model_step(v, s);
    tick(v, s);
    check_model(t);
  endtask

  task automatic check_zero(input string t);
    chk({t, ".bf4"}, int'(bf4), 0);
    chk({t, ".tw4"}, int'(tw4), 0);
    chk({t, ".ov4"}, int'(ov4), 0);
    chk({t, ".os4"}, int'(os4), 0);
    chk({t, ".er4"}, int'(er4), 0);
    chk({t, ".bf2"}, int'(bf2), 0);
    chk({t, ".tw2"}, int'(tw2), 0);
    chk({t, ".ov2"}, int'(ov2), 0);
    chk({t, ".os2"}, int'(os2), 0);
    chk({t, ".er2"}, int'(er2), 0);
  endtask

  initial begin
    int n_os4, n_os2, n_gap, first_ov;

    //           v  s  bf4 tw4 ov4 os4 bf2 tw2 ov2 os2
    vt[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 1, 0, 0, 0, 2, 0, 0};
    vt[2]  = '{1, 0, 0, 2, 0, 0, 1, 0, 1, 1};
    vt[3]  = '{1, 0, 0, 3, 0, 0, 1, 0, 1, 0};
    vt[4]  = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 0};
    vt[5]  = '{1, 0, 1, 0, 1, 0, 0, 2, 1, 0};
    vt[6]  = '{0, 0, 1, 0, 0, 0, 0, 2, 0, 0};
    vt[7]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    vt[8]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    vt[9]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    vt[10] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    vt[11] = '{1, 0, 0, 1, 1, 0, 0, 2, 1, 0};
    vt[12] = '{1, 0, 0, 2, 1, 0, 1, 0, 1, 0};
    vt[13] = '{1, 0, 0, 3, 1, 0, 1, 0, 1, 0};

    rst = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      model_step(vt[i].v, vt[i].s);
      tick(vt[i].v, vt[i].s);
      chk($sformatf("v%0d.bf4", i), int'(bf4), vt[i].bf4);
      chk($sformatf("v%0d.tw4", i), int'(tw4), vt[i].tw4);
      chk($sformatf("v%0d.ov4", i), int'(ov4), vt[i].ov4);
      chk($sformatf("v%0d.os4", i), int'(os4), vt[i].os4);
      chk($sformatf("v%0d.bf2", i), int'(bf2), vt[i].bf2);
      chk($sformatf("v%0d.tw2", i), int'(tw2), vt[i].tw2);
      chk($sformatf("v%0d.ov2", i), int'(ov2), vt[i].ov2);
      chk($sformatf("v%0d.os2", i), int'(os2), vt[i].os2);
      chk($sformatf("v%0d.err", i), int'(er4 | er2), 0);
    end

    while (mk != 0) step(1, 0, "frame1");

    n_os4 = 0; n_os2 = 0; n_gap = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, (i == 0) ? 1 : 0, "b2b");
      n_os4 += int'(os4);
      n_os2 += int'(os2);
      if (!ov4 || !ov2) n_gap++;
    end
    chk("b2b.sop_count4", n_os4, 1);
    chk("b2b.sop_count2", n_os2, 1);
    chk("b2b.gaps", n_gap, 0);
    chk("b2b.no_err", int'(er4 | er2), 0);

    step(1, 1, "f3");
    while (mk != 37) step(1, 0, "f3");
    step(1, 1, "inj");
    chk("inj.sop_err4", int'(er4), 1);
    chk("inj.sop_err2", int'(er2), 1);
    n_gap = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, "post_inj");
      n_gap += int'(ov4);
    end
    chk("inj.quiet4", n_gap, 0);
    step(1, 0, "realigned");
    chk("inj.out_sop4", int'(os4), 1);
    chk("inj.tw4", int'(tw4), 0);
    for (int i = 0; i < 4; i++) step(1, 0, "post_sop");

    for (int i = 0; i < 16; i++)
      step((i % 2 == 0) ? 1 : 0, 0, "toggle");

    while (mk != 20) step(1, 0, "to20");
    @(negedge clk);
    in_valid = 1'b0;
    in_sop = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    first_ov = -1;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, "reprime");
      if (first_ov < 0 && ov4) first_ov = i;
    end
    chk("reprime.first_ov4", first_ov, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_sequencer.md
FFT_TWIDDLE_SEQUENCER -- requirements
Module: fft_twiddle_sequencer

Interface
REQ-001 Parameter NFFT, default 64: frame length in samples; power of two, at most 64.
REQ-002 Parameter DELAY, default 4: SDF delay-line depth of the controlled stage; legal values 2 (W4 twiddles) or 4 (W8 twiddles).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  a sample is presented to the stage this cycle; the SDF delay line advances only on in_valid=1.
REQ-006 in_sop  input  1  start of frame; qualified by in_valid.
REQ-007 bf_en  output  1  butterfly compute (1) or delay-line fill/pass (0).
REQ-008 tw_addr  output  6  constant-multiplier address: 0=W^0, 1=W8^1, 2=W8^2 (-j), 3=W8^3.
REQ-009 out_valid  output  1  the constant-multiplier output is a valid stage output this cycle.
REQ-010 out_sop  output  1  marks output index j=0 of a frame; coincides with out_valid.
REQ-011 sop_err  output  1  sticky flag: in_sop arrived mid-frame.

Function
REQ-012 A 6-bit input counter cnt shall increment modulo NFFT on every cycle with in_valid=1 and hold otherwise.
REQ-013 in_valid=1 with in_sop=1 shall treat the current sample as cnt=0, so the counter holds 1 after that edge.
REQ-014 Input phase shall be bit log2(DELAY) of cnt for the accepted sample: phase 0 = fill, phase 1 = compute.
REQ-015 On each in_valid edge, bf_en shall register the accepted sample's phase.
REQ-016 bf_en and tw_addr shall hold their values while in_valid=0.
REQ-017 The output index shall be j = (cnt_accepted - DELAY) mod NFFT.
REQ-018 If bit log2(DELAY) of j is 0 (sum outputs), tw_addr shall register 0.
REQ-019 Otherwise (difference outputs), tw_addr shall register (j mod DELAY) * (4/DELAY): sequence 0,1,2,3 for DELAY=4 and 0,2 for DELAY=2.
REQ-020 A primed flag shall set once DELAY samples have been accepted since reset or since the last realigning sop.
REQ-021 out_valid shall be a registered copy of (in_valid and primed-after-this-sample), giving 1-cycle latency that matches the multiplier product register.
REQ-022 While in_valid=0, out_valid shall be 0 on the next cycle.
REQ-023 out_sop shall register 1 when the accepted sample has cnt_accepted = DELAY and primed is set; it shall be 0 otherwise.
REQ-024 in_sop with in_valid when cnt is nonzero shall set sop_err, realign cnt per REQ-013, and clear primed.
REQ-025 Following REQ-024, out_valid shall stay low for the next DELAY accepted samples (the partial frame is discarded).
REQ-026 in_sop when cnt=0 shall be legal and shall not disturb primed, so back-to-back frames stream without gaps.
REQ-027 in_sop with in_valid=0 shall be ignored.
REQ-028 cnt wraps NFFT-1 -> 0 without an sop; the next frame continues seamlessly.

Reset
REQ-029 rst=0 shall asynchronously clear cnt, primed, bf_en, tw_addr, out_valid, out_sop and sop_err to 0.
REQ-030 Reset asserted mid-frame shall discard all progress; after release the block behaves as freshly primed from zero.
REQ-031 sop_err shall clear only on reset.

Structure
REQ-032 NFFT, the twiddle address encodings (TW_W0=0, TW_W8_1=1, TW_W8_2=2, TW_W8_3=3) and DATA_WIDTH defaults shall live in the shared fft_pkg package.
REQ-033 The block shall be flat RTL with no sub-module; every output shall be registered.

Verification
REQ-034 DELAY=4: reset, then 64 continuous valid samples with sop on sample 0 -> first out_valid one cycle after sample 4 with out_sop=1; bf_en=1 for cnt 4-7, 12-15, ...; tw_addr 0,0,0,0,0,1,2,3 repeating.
REQ-035 DELAY=2: same stimulus -> tw_addr 0,0,0,2 repeating; first out_valid after sample 2.
REQ-036 in_valid toggled 1,0,1,0 -> out_valid mirrors it with 1-cycle lag; tw_addr and bf_en are unchanged across gaps; the sequence is identical to REQ-034 when gaps are removed.
REQ-037 sop injected at cnt=37 -> sop_err=1; no out_valid for the next 4 accepted samples; then out_sop=1 with tw_addr=0.
REQ-038 Back-to-back frames with sop at every cnt=0 -> sop_err stays 0; out_valid is continuous; out_sop recurs every 64 outputs.
REQ-039 rst pulsed low at cnt=20 -> all outputs 0 immediately; after release, priming restarts (4 samples).
